// File: rtl/serial_tx_sequencer_pkg.sv
// Shared definitions for the serial transmit sequencer: FSM state encoding,
// shift-register command codes and Gray-code bit-index helpers.
package serial_tx_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_GAP   = 2'b11
  } state_t;

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_RIGHT = 2'b01;
  localparam logic [1:0] SR_LEFT  = 2'b10;
  localparam logic [1:0] SR_LOAD  = 2'b11;

  // Gray code of the last bit index (3) in a 4-bit frame
  localparam logic [1:0] GRAY_LAST = 2'b10;

  function automatic logic [1:0] gray_step(input logic [1:0] g);
    logic [1:0] nxt;
    case (g)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      2'b10:   nxt = 2'b00;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] gray_decode(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/serial_tx_sequencer_gray_bitcounter.sv
// Two-bit Gray-coded bit index: clears to 00, steps 00-01-11-10 and wraps.
module gray_bitcounter
  import serial_tx_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  output logic [1:0] count
);

  // Gray index register; clear has priority over advance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 2'b00;
    end else if (clear) begin
      count <= 2'b00;
    end else if (advance) begin
      count <= gray_step(count);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/serial_tx_sequencer.sv
// Serialises one 4-bit word per frame onto serial_out, LSB or MSB first,
// driving a companion shift register and inserting GAP_CYCLES idle cycles.
module serial_tx_sequencer
  import serial_tx_sequencer_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       direction,
  input  logic       hold,
  output logic [1:0] sr_sel,
  output logic       sr_enable,
  output logic [3:0] sr_load,
  output logic       serial_out,
  output logic       serial_valid,
  output logic [1:0] bit_count,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [2:0] GAP_LAST = 3'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t     state_r;
  logic [3:0] word_r;
  logic       dir_r;
  logic [2:0] gap_cnt_r;
  logic       in_shift_s;
  logic       step_s;
  logic       clear_s;
  logic [1:0] idx_s;

  assign in_shift_s = (state_r == ST_SHIFT);
  assign step_s     = in_shift_s && !hold;
  assign clear_s    = !in_shift_s;
  assign idx_s      = gray_decode(bit_count);

  gray_bitcounter u_bitcnt (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear_s),
    .advance (step_s),
    .count   (bit_count)
  );

  // Frame sequencing; the word and direction are captured only on accept
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      word_r    <= 4'b0000;
      dir_r     <= 1'b0;
      gap_cnt_r <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (data_valid) begin
            word_r  <= data_in;
            dir_r   <= direction;
            state_r <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          gap_cnt_r <= 3'd0;
          state_r   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (step_s && (bit_count == GRAY_LAST)) begin
            state_r <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_r <= 3'd0;
            state_r   <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + 3'd1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Shift-register command and serial bit, decoded from state; hold masks shifting
  always_comb begin
    sr_sel       = SR_HOLD;
    sr_enable    = 1'b0;
    serial_valid = 1'b0;
    serial_out   = 1'b0;
    frame_done   = 1'b0;
    case (state_r)
      ST_LOAD: begin
        sr_sel    = SR_LOAD;
        sr_enable = 1'b1;
      end
      ST_SHIFT: begin
        serial_out = dir_r ? word_r[2'd3 - idx_s] : word_r[idx_s];
        if (!hold) begin
          sr_sel       = dir_r ? SR_LEFT : SR_RIGHT;
          sr_enable    = 1'b1;
          serial_valid = 1'b1;
          frame_done   = (bit_count == GRAY_LAST);
        end else begin
          sr_sel    = SR_HOLD;
          sr_enable = 1'b0;
        end
      end
      default: begin
        sr_sel    = SR_HOLD;
        sr_enable = 1'b0;
      end
    endcase
  end

  assign sr_load    = word_r;
  assign data_ready = (state_r == ST_IDLE);
  assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_serial_tx_sequencer.sv
// Drives two sequencers (GAP_CYCLES=1 and 0) with shared directed and random
// stimulus and compares every output each cycle against a frame-position model.
module tb_serial_tx_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] data_in;
  logic       data_valid;
  logic       direction;
  logic       hold;

  logic       rdy [2];
  logic [1:0] sel [2];
  logic       en  [2];
  logic [3:0] ld  [2];
  logic       so  [2];
  logic       sv  [2];
  logic [1:0] bc  [2];
  logic       fd  [2];
  logic       bsy [2];

  // Model: position within the frame (0 idle, 1 load, 2..5 bits, 6.. gap)
  int         p [2];
  logic [3:0] w [2];
  logic       d [2];

  int passes = 0;
  int total  = 0;

  always #5 clock = ~clock;

  serial_tx_sequencer #(.GAP_CYCLES(1)) dut_g1 (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy[0]), .direction(direction), .hold(hold), .sr_sel(sel[0]),
    .sr_enable(en[0]), .sr_load(ld[0]), .serial_out(so[0]), .serial_valid(sv[0]),
    .bit_count(bc[0]), .frame_done(fd[0]), .busy(bsy[0])
  );

  serial_tx_sequencer #(.GAP_CYCLES(0)) dut_g0 (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy[1]), .direction(direction), .hold(hold), .sr_sel(sel[1]),
    .sr_enable(en[1]), .sr_load(ld[1]), .serial_out(so[1]), .serial_valid(sv[1]),
    .bit_count(bc[1]), .frame_done(fd[1]), .busy(bsy[1])
  );

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input int k, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s gap=%0d t=%0t observed=%h expected=%h", tag, gap_of(k), $time, obs, exp);
  endtask

  task automatic check_inst(input int k);
    int         i;
    logic [1:0] e_sel;
    logic [1:0] e_bc;
    logic       e_en, e_sv, e_so, e_fd;
    e_sel = 2'b00; e_bc = 2'b00; e_en = 1'b0; e_sv = 1'b0; e_so = 1'b0; e_fd = 1'b0;
    i = p[k] - 2;
    if (p[k] == 1) begin
      e_sel = 2'b11;
      e_en  = 1'b1;
    end else if (p[k] >= 2 && p[k] <= 5) begin
      e_bc = 2'(i ^ (i >> 1));
      e_so = d[k] ? w[k][2'(3 - i)] : w[k][2'(i)];
      if (!hold) begin
        e_sel = d[k] ? 2'b10 : 2'b01;
        e_en  = 1'b1;
        e_sv  = 1'b1;
        e_fd  = (i == 3);
      end
    end
    chk("data_ready",   k, 4'(rdy[k]), 4'(p[k] == 0));
    chk("busy",         k, 4'(bsy[k]), 4'(p[k] != 0));
    chk("sr_sel",       k, 4'(sel[k]), 4'(e_sel));
    chk("sr_enable",    k, 4'(en[k]),  4'(e_en));
    chk("serial_valid", k, 4'(sv[k]),  4'(e_sv));
    chk("serial_out",   k, 4'(so[k]),  4'(e_so));
    chk("bit_count",    k, 4'(bc[k]),  4'(e_bc));
    chk("frame_done",   k, 4'(fd[k]),  4'(e_fd));
    if (p[k] == 1 || reset) chk("sr_load", k, ld[k], w[k]);
  endtask

  task automatic model_step(input int k);
    if (p[k] == 0) begin
      if (data_valid) begin
        w[k] = data_in;
        d[k] = direction;
        p[k] = 1;
      end
    end else if (p[k] == 1) begin
      p[k] = 2;
    end else if (p[k] <= 5) begin
      if (!hold) p[k] = (p[k] == 5) ? ((gap_of(k) > 0) ? 6 : 0) : p[k] + 1;
    end else begin
      p[k] = (p[k] == 5 + gap_of(k)) ? 0 : p[k] + 1;
    end
  endtask

  task automatic cyc(input logic rv, input logic dv, input logic [3:0] din,
                     input logic dr, input logic hv);
    reset = rv; data_valid = dv; data_in = din; direction = dr; hold = hv;
    if (rv) begin
      for (int k = 0; k < 2; k++) begin
        p[k] = 0; w[k] = 4'b0000; d[k] = 1'b0;
      end
    end
    #2;
    for (int k = 0; k < 2; k++) check_inst(k);
    @(posedge clock);
    if (!rv) begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      p[k] = 0; w[k] = 4'b0000; d[k] = 1'b0;
    end
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'b1111, 1'b1, 1'b1);
    idle(2);

    // LSB-first then MSB-first frames of 1011
    cyc(1'b0, 1'b1, 4'b1011, 1'b0, 1'b0);
    idle(8);
    cyc(1'b0, 1'b1, 4'b1011, 1'b1, 1'b0);
    idle(8);

    // Hold for three cycles while bit index 1 is on the line
    cyc(1'b0, 1'b1, 4'b0110, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    idle(8);

    // Reset pulsed at bit index 2, then a normal frame
    cyc(1'b0, 1'b1, 4'b1101, 1'b1, 1'b0);
    idle(3);
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 1'b1, 4'b1001, 1'b0, 1'b0);
    idle(8);

    // data_valid held high: back-to-back frames, 0110 then 1001
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b1, 4'b0110, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) cyc(1'b0, 1'b1, 4'b1001, 1'b1, 1'b0);
    idle(8);

    // data_valid toggled with new words during an in-flight frame
    cyc(1'b0, 1'b1, 4'b0011, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) cyc(1'b0, 1'(c % 2), 4'(c * 5), 1'(c % 3 == 0), 1'b0);
    idle(4);

    // Randomised traffic with occasional hold and reset
    for (int n = 0; n < 500; n++) begin
      cyc(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)), 4'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/serial_tx_sequencer.md
SERIAL_TX_SEQUENCER -- requirements
Module: serial_tx_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 1: idle cycles forced between frames; legal range 0..7.
REQ-002 clock  input  1  the only clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_in  input  4  word to transmit; sampled on accept.
REQ-005 data_valid  input  1  requester has a word on data_in.
REQ-006 data_ready  output  1  sequencer can accept a word this cycle.
REQ-007 direction  input  1  0 = LSB first (shift right), 1 = MSB first (shift left); sampled on accept.
REQ-008 hold  input  1  pause shifting while high.
REQ-009 sr_sel  output  2  shift-register command: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-010 sr_enable  output  1  shift-register clock enable.
REQ-011 sr_load  output  4  parallel word for the shift register; valid when sr_sel=11.
REQ-012 serial_out  output  1  current transmitted bit.
REQ-013 serial_valid  output  1  serial_out carries a frame bit this cycle.
REQ-014 bit_count  output  2  Gray-coded index of the bit being sent.
REQ-015 frame_done  output  1  one-cycle pulse with the last bit of a frame.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SHIFT and GAP.
REQ-018 IDLE: data_ready=1; on data_valid=1, latch data_in and direction, go to LOAD next cycle.
REQ-019 data_ready SHALL be 0 in LOAD, SHIFT and GAP; data_valid there is ignored, with no queuing.
REQ-020 LOAD (1 cycle): sr_sel=11, sr_enable=1, sr_load=latched word; serial_valid=0; go to SHIFT.
REQ-021 SHIFT: serial_valid=1, serial_out = word[idx] (LSB first) or word[3-idx] (MSB first), where idx is the decoded bit_count.
REQ-022 While in SHIFT, sr_sel SHALL be 01 (direction 0) or 10 (direction 1), with sr_enable=1.
REQ-023 bit_count SHALL step 00, 01, 11, 10 (Gray) on each SHIFT cycle not held, and wrap to 00 on frame end.
REQ-024 Held SHIFT cycle (hold=1): serial_valid=0, sr_sel=00, sr_enable=0, bit_count and state frozen.
REQ-025 hold SHALL have no effect in IDLE, LOAD or GAP.
REQ-026 frame_done=1 SHALL coincide with the un-held SHIFT cycle at bit_count=10.
REQ-027 After that cycle, the FSM SHALL go to GAP if GAP_CYCLES>0, else to IDLE.
REQ-028 GAP: sr_sel=00, sr_enable=0, serial_valid=0; after exactly GAP_CYCLES cycles, go to IDLE.
REQ-029 Accept-to-first-bit latency SHALL be 2 cycles; with no hold, a frame takes 1+4+GAP_CYCLES cycles after accept.
REQ-030 Outside SHIFT, serial_out SHALL be 0 and bit_count SHALL be 00.

Reset
REQ-031 Asserting reset at any time, mid-frame included, SHALL immediately force IDLE and abort the frame with no frame_done.
REQ-032 Reset values: data_ready=1, busy=0, sr_sel=00, sr_enable=0, sr_load=0000, serial_out=0, serial_valid=0, bit_count=00, frame_done=0.

Structure
REQ-033 A shared package SHALL hold the state encoding, the sr_sel command constants and the Gray step/decode function.
REQ-034 The Gray bit counter SHALL be a sub-module named gray_bitcounter (clock, reset, clear, advance, count).
REQ-035 Outputs SHALL be registered or decoded from state only; there is no combinational path from data_valid to serial_out.

Verification
REQ-036 GAP_CYCLES=1, accept 1011 (direction 0), hold=0 -> sr_sel=11 for 1 cycle, then serial_out 1,1,0,1; bit_count 00,01,11,10; frame_done on 4th bit; data_ready back 2 cycles later.
REQ-037 Accept 1011 (direction 1) -> serial_out 1,0,1,1 and sr_sel=10 for 4 cycles.
REQ-038 hold=1 for 3 cycles during bit index 1 -> serial_valid low for 3 cycles, bit_count stays 01, frame stretched by 3 cycles.
REQ-039 Reset pulsed at bit index 2 -> all outputs at reset values immediately, no frame_done; next accept transmits normally.
REQ-040 GAP_CYCLES=0, data_valid held high with 0110 then 1001 -> back-to-back frames, each accepted in the cycle after the previous frame_done.
REQ-041 data_valid toggled during LOAD, SHIFT and GAP -> data_ready stays 0 and the in-flight word is unaffected.
